// File: rtl/tetris_rotate_ctrl.sv
// Rotation controller for a falling tetromino: derives rotated cell offsets and
// walks a wall-kick sequence through an external collision checker.
module tetris_rotate_ctrl #(
    parameter int NUM_KICKS = 3,
    parameter int OFS_W     = 2,
    parameter int KICK_W    = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spawn_valid,
    input  logic [2:0]        spawn_shape,
    input  logic              rot_req,
    input  logic              rot_dir,
    output logic              q_valid,
    output logic [1:0]        q_rot,
    output logic [KICK_W-1:0] q_kick,
    output logic [OFS_W-1:0]  q_dx0,
    output logic [OFS_W-1:0]  q_dx1,
    output logic [OFS_W-1:0]  q_dx2,
    output logic [OFS_W-1:0]  q_dx3,
    output logic [OFS_W-1:0]  q_dy0,
    output logic [OFS_W-1:0]  q_dy1,
    output logic [OFS_W-1:0]  q_dy2,
    output logic [OFS_W-1:0]  q_dy3,
    input  logic              q_ready,
    input  logic              q_hit,
    output logic [2:0]        cur_shape,
    output logic [1:0]        cur_rot,
    output logic [KICK_W-1:0] cur_kick,
    output logic [OFS_W-1:0]  cur_dx0,
    output logic [OFS_W-1:0]  cur_dx1,
    output logic [OFS_W-1:0]  cur_dx2,
    output logic [OFS_W-1:0]  cur_dx3,
    output logic [OFS_W-1:0]  cur_dy0,
    output logic [OFS_W-1:0]  cur_dy1,
    output logic [OFS_W-1:0]  cur_dy2,
    output logic [OFS_W-1:0]  cur_dy3,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    typedef enum logic {IDLE = 1'b0, QUERY = 1'b1} state_t;

    typedef struct packed {
        logic [3:0][1:0] x;
        logic [3:0][1:0] y;
    } cells_t;

    state_t                   state_q, state_d;
    logic [1:0]               target_q, target_d;
    logic [1:0]               k_q, k_d;
    logic [1:0]               cur_rot_q, cur_rot_d;
    logic [2:0]               cur_shape_q, cur_shape_d;
    logic signed [KICK_W-1:0] cur_kick_q, cur_kick_d;
    logic                     done_q, done_d;
    logic                     fail_q, fail_d;
    logic [1:0]               next_rot;
    logic signed [KICK_W-1:0] kick_now;
    cells_t                   cur_c, q_c;

    // Rot-0 occupancy in a 4x4 box, bit index y*4+x.
    function automatic logic [15:0] base_mask(input logic [2:0] shape);
        case (shape)
            3'd0:    base_mask = 16'h0066;
            3'd1:    base_mask = 16'h00F0;
            3'd2:    base_mask = 16'h0072;
            3'd3:    base_mask = 16'h0036;
            3'd4:    base_mask = 16'h0063;
            3'd5:    base_mask = 16'h0071;
            3'd6:    base_mask = 16'h0074;
            default: base_mask = 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] rotate_cw(input logic [15:0] m, input int n);
        logic [15:0] r;
        r = '0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                if (x < n && y < n && m[4'(y * 4 + x)])
                    r[4'(x * 4 + n - 1 - y)] = 1'b1;
        return r;
    endfunction

    function automatic cells_t shape_cells(input logic [2:0] shape, input logic [1:0] rot);
        logic [15:0] m;
        cells_t      c;
        int          cnt;
        int          n;
        m = base_mask(shape);
        n = (shape == 3'd1) ? 4 : 3;
        if (shape != 3'd0)
            for (int i = 0; i < 3; i++)
                if (i < int'(rot)) m = rotate_cw(m, n);
        c   = '0;
        cnt = 0;
        // Scanning the mask in bit order already yields row-major sorted cells.
        for (int b = 0; b < 16; b++)
            if (m[4'(b)] && cnt < 4) begin
                c.x[2'(cnt)] = 2'(b % 4);
                c.y[2'(cnt)] = 2'(b / 4);
                cnt++;
            end
        return c;
    endfunction

    function automatic logic signed [KICK_W-1:0] kick_of(input logic [1:0] k);
        case (k)
            2'd1:    kick_of = KICK_W'(-1);
            2'd2:    kick_of = KICK_W'(1);
            2'd3:    kick_of = KICK_W'(-2);
            default: kick_of = '0;
        endcase
    endfunction

    assign next_rot = rot_dir ? (cur_rot_q - 2'd1) : (cur_rot_q + 2'd1);
    assign kick_now = kick_of(k_q);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        k_d         = k_q;
        cur_shape_d = cur_shape_q;
        cur_rot_d   = cur_rot_q;
        cur_kick_d  = cur_kick_q;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        if (spawn_valid) begin
            cur_shape_d = spawn_shape;
            cur_rot_d   = '0;
            cur_kick_d  = '0;
            k_d         = '0;
            state_d     = IDLE;
        end else if (state_q == IDLE) begin
            if (rot_req) begin
                case (cur_shape_q)
                    3'd0: begin
                        cur_rot_d  = next_rot;
                        cur_kick_d = '0;
                        done_d     = 1'b1;
                    end
                    3'd7:    fail_d = 1'b1;
                    default: begin
                        target_d = next_rot;
                        k_d      = '0;
                        state_d  = QUERY;
                    end
                endcase
            end
        end else if (q_ready) begin
            if (!q_hit) begin
                cur_rot_d  = target_q;
                cur_kick_d = kick_now;
                done_d     = 1'b1;
                state_d    = IDLE;
            end else if (k_q == 2'(NUM_KICKS - 1)) begin
                fail_d  = 1'b1;
                state_d = IDLE;
            end else begin
                k_d = k_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            target_q    <= '0;
            k_q         <= '0;
            cur_shape_q <= '0;
            cur_rot_q   <= '0;
            cur_kick_q  <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            k_q         <= k_d;
            cur_shape_q <= cur_shape_d;
            cur_rot_q   <= cur_rot_d;
            cur_kick_q  <= cur_kick_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign cur_c = shape_cells(cur_shape_q, cur_rot_q);
    assign q_c   = shape_cells(cur_shape_q, target_q);

    assign busy      = (state_q == QUERY);
    assign q_valid   = (state_q == QUERY);
    assign done      = done_q;
    assign fail      = fail_q;
    assign q_rot     = target_q;
    assign q_kick    = kick_now;
    assign cur_shape = cur_shape_q;
    assign cur_rot   = cur_rot_q;
    assign cur_kick  = cur_kick_q;

    assign q_dx0   = OFS_W'(q_c.x[0]);
    assign q_dx1   = OFS_W'(q_c.x[1]);
    assign q_dx2   = OFS_W'(q_c.x[2]);
    assign q_dx3   = OFS_W'(q_c.x[3]);
    assign q_dy0   = OFS_W'(q_c.y[0]);
    assign q_dy1   = OFS_W'(q_c.y[1]);
    assign q_dy2   = OFS_W'(q_c.y[2]);
    assign q_dy3   = OFS_W'(q_c.y[3]);
    assign cur_dx0 = OFS_W'(cur_c.x[0]);
    assign cur_dx1 = OFS_W'(cur_c.x[1]);
    assign cur_dx2 = OFS_W'(cur_c.x[2]);
    assign cur_dx3 = OFS_W'(cur_c.x[3]);
    assign cur_dy0 = OFS_W'(cur_c.y[0]);
    assign cur_dy1 = OFS_W'(cur_c.y[1]);
    assign cur_dy2 = OFS_W'(cur_c.y[2]);
    assign cur_dy3 = OFS_W'(cur_c.y[3]);

endmodule

// File: tb/tb_tetris_rotate_ctrl.sv
// Bench for tetris_rotate_ctrl: directed scenarios plus a per-cycle compare
// against a coordinate-list model of the piece and the kick walk.
module tb_tetris_rotate_ctrl;

    localparam int NUM_KICKS = 3;
    localparam int OFS_W     = 2;
    localparam int KICK_W    = 3;

    localparam int SX [7][4] = '{'{1,2,1,2}, '{0,1,2,3}, '{1,0,1,2}, '{1,2,0,1},
                                 '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
    localparam int SY [7][4] = '{'{0,0,1,1}, '{1,1,1,1}, '{0,1,1,1}, '{0,0,1,1},
                                 '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};
    localparam int KICKS [4] = '{0, -1, 1, -2};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic spawn_valid = 1'b0;
    logic [2:0] spawn_shape = 3'd0;
    logic rot_req = 1'b0;
    logic rot_dir = 1'b0;
    logic q_ready = 1'b0;
    logic q_hit = 1'b0;
    logic q_valid, busy, done, fail;
    logic [1:0] q_rot, cur_rot;
    logic [2:0] cur_shape;
    logic [KICK_W-1:0] q_kick, cur_kick;
    logic [OFS_W-1:0] qdx [4];
    logic [OFS_W-1:0] qdy [4];
    logic [OFS_W-1:0] cdx [4];
    logic [OFS_W-1:0] cdy [4];

    int n_chk = 0;
    int n_pass = 0;

    int m_shape, m_rot, m_kick, m_busy, m_tgt, m_k, m_done, m_fail;

    tetris_rotate_ctrl #(.NUM_KICKS(NUM_KICKS), .OFS_W(OFS_W), .KICK_W(KICK_W)) dut (
        .clk(clk), .resetn(resetn),
        .spawn_valid(spawn_valid), .spawn_shape(spawn_shape),
        .rot_req(rot_req), .rot_dir(rot_dir),
        .q_valid(q_valid), .q_rot(q_rot), .q_kick(q_kick),
        .q_dx0(qdx[0]), .q_dx1(qdx[1]), .q_dx2(qdx[2]), .q_dx3(qdx[3]),
        .q_dy0(qdy[0]), .q_dy1(qdy[1]), .q_dy2(qdy[2]), .q_dy3(qdy[3]),
        .q_ready(q_ready), .q_hit(q_hit),
        .cur_shape(cur_shape), .cur_rot(cur_rot), .cur_kick(cur_kick),
        .cur_dx0(cdx[0]), .cur_dx1(cdx[1]), .cur_dx2(cdx[2]), .cur_dx3(cdx[3]),
        .cur_dy0(cdy[0]), .cur_dy1(cdy[1]), .cur_dy2(cdy[2]), .cur_dy3(cdy[3]),
        .busy(busy), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Rotate the rot-0 coordinate list r times, then sort by y*4+x.
    function automatic int cell_coord(input int sh, input int r, input int idx, input bit want_y);
        int x[4], y[4], key[4], n, t;
        if (sh > 6) return 0;
        for (int i = 0; i < 4; i++) begin
            x[i] = SX[sh][i];
            y[i] = SY[sh][i];
        end
        n = (sh == 1) ? 4 : 3;
        if (sh != 0)
            for (int s = 0; s < r; s++)
                for (int i = 0; i < 4; i++) begin
                    t = x[i];
                    x[i] = n - 1 - y[i];
                    y[i] = t;
                end
        for (int i = 0; i < 4; i++) key[i] = y[i] * 4 + x[i];
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3 - a; b++)
                if (key[b] > key[b + 1]) begin
                    t = key[b];
                    key[b] = key[b + 1];
                    key[b + 1] = t;
                end
        return want_y ? key[idx] / 4 : key[idx] % 4;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_shape <= 0; m_rot <= 0; m_kick <= 0; m_busy <= 0;
            m_tgt <= 0; m_k <= 0; m_done <= 0; m_fail <= 0;
        end else begin
            m_done <= 0;
            m_fail <= 0;
            if (spawn_valid) begin
                m_shape <= int'(spawn_shape); m_rot <= 0; m_kick <= 0; m_busy <= 0; m_k <= 0;
            end else if (m_busy == 0) begin
                if (rot_req) begin
                    if (m_shape == 0) begin
                        m_rot <= (m_rot + (rot_dir ? 3 : 1)) % 4; m_kick <= 0; m_done <= 1;
                    end else if (m_shape == 7) begin
                        m_fail <= 1;
                    end else begin
                        m_busy <= 1; m_tgt <= (m_rot + (rot_dir ? 3 : 1)) % 4; m_k <= 0;
                    end
                end
            end else if (q_ready) begin
                if (!q_hit) begin
                    m_rot <= m_tgt; m_kick <= KICKS[m_k]; m_busy <= 0; m_done <= 1;
                end else if (m_k < NUM_KICKS - 1) begin
                    m_k <= m_k + 1;
                end else begin
                    m_busy <= 0; m_fail <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), m_busy);
        chk("q_valid", int'(q_valid), m_busy);
        chk("done", int'(done), m_done);
        chk("fail", int'(fail), m_fail);
        chk("cur_shape", int'(cur_shape), m_shape);
        chk("cur_rot", int'(cur_rot), m_rot);
        chk("cur_kick", int'($signed(cur_kick)), m_kick);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cur_dx%0d", i), int'(cdx[i]), cell_coord(m_shape, m_rot, i, 1'b0));
            chk($sformatf("cur_dy%0d", i), int'(cdy[i]), cell_coord(m_shape, m_rot, i, 1'b1));
        end
        if (m_busy != 0) begin
            chk("q_rot", int'(q_rot), m_tgt);
            chk("q_kick", int'($signed(q_kick)), KICKS[m_k]);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("q_dx%0d", i), int'(qdx[i]), cell_coord(m_shape, m_tgt, i, 1'b0));
                chk($sformatf("q_dy%0d", i), int'(qdy[i]), cell_coord(m_shape, m_tgt, i, 1'b1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spawn(input logic [2:0] sh);
        spawn_valid = 1'b1;
        spawn_shape = sh;
        tick();
        spawn_valid = 1'b0;
    endtask

    task automatic do_rot(input logic dir);
        rot_req = 1'b1;
        rot_dir = dir;
        tick();
        rot_req = 1'b0;
    endtask

    task automatic chk_cells(input string nm, input bit use_q,
                             input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2, input int x3, input int y3);
        int ex[4], ey[4];
        ex = '{x0, x1, x2, x3};
        ey = '{y0, y1, y2, y3};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_x%0d", nm, i), int'(use_q ? qdx[i] : cdx[i]), ex[i]);
            chk($sformatf("%s_y%0d", nm, i), int'(use_q ? qdy[i] : cdy[i]), ey[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] snap;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_cur_shape", int'(cur_shape), 0);
        resetn = 1'b1;
        tick();

        // T clockwise, accepted on the first query.
        spawn(3'd2);
        do_rot(1'b0);
        chk("t_q_valid", int'(q_valid), 1);
        chk("t_q_rot", int'(q_rot), 1);
        chk_cells("t_q", 1'b1, 1, 0, 1, 1, 2, 1, 1, 2);
        q_ready = 1'b1; q_hit = 1'b0;
        tick();
        q_ready = 1'b0;
        chk("t_done", int'(done), 1);
        chk("t_cur_rot", int'(cur_rot), 1);
        chk("t_cur_kick", int'($signed(cur_kick)), 0);
        tick();

        // I counter-clockwise, two hits then clear.
        spawn(3'd1);
        do_rot(1'b1);
        q_ready = 1'b1; q_hit = 1'b1;
        chk("i_kick0", int'($signed(q_kick)), 0);
        tick();
        chk("i_kick1", int'($signed(q_kick)), -1);
        chk("i_q_valid", int'(q_valid), 1);
        tick();
        chk("i_kick2", int'($signed(q_kick)), 1);
        q_hit = 1'b0;
        tick();
        q_ready = 1'b0;
        chk("i_done", int'(done), 1);
        chk("i_cur_rot", int'(cur_rot), 3);
        chk("i_cur_kick", int'($signed(cur_kick)), 1);
        tick();

        // J clockwise, every kick collides.
        spawn(3'd5);
        do_rot(1'b0);
        q_ready = 1'b1; q_hit = 1'b1;
        tick();
        tick();
        chk("j_no_fail_yet", int'(fail), 0);
        tick();
        q_ready = 1'b0; q_hit = 1'b0;
        chk("j_fail", int'(fail), 1);
        chk("j_done", int'(done), 0);
        chk("j_cur_rot", int'(cur_rot), 0);
        chk("j_cur_kick", int'($signed(cur_kick)), 0);
        chk_cells("j_cur", 1'b0, 0, 0, 0, 1, 1, 1, 2, 1);
        tick();

        // Checker stalls; a second request during the stall is dropped.
        spawn(3'd2);
        do_rot(1'b0);
        snap = {q_rot, q_kick, qdx[0], qdx[1], qdx[2], qdx[3], qdy[0], qdy[1], qdy[2], qdy[3]};
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rot_req = 1'b1; rot_dir = 1'b1;
            end
            tick();
            rot_req = 1'b0;
            chk("stall_q_valid", int'(q_valid), 1);
            chk("stall_stable", int'({q_rot, q_kick, qdx[0], qdx[1], qdx[2], qdx[3],
                                      qdy[0], qdy[1], qdy[2], qdy[3]}), int'(snap));
        end
        q_ready = 1'b1; q_hit = 1'b0;
        tick();
        q_ready = 1'b0;
        chk("stall_done", int'(done), 1);
        chk("stall_cur_rot", int'(cur_rot), 1);
        tick();
        chk("stall_no_requeue", int'(busy), 0);

        // Spawn during a query beats rot_req and q_ready.
        spawn(3'd4);
        do_rot(1'b0);
        q_ready = 1'b1; q_hit = 1'b0; rot_req = 1'b1;
        spawn(3'd3);
        q_ready = 1'b0; rot_req = 1'b0;
        chk("sp_q_valid", int'(q_valid), 0);
        chk("sp_cur_shape", int'(cur_shape), 3);
        chk("sp_cur_rot", int'(cur_rot), 0);
        chk("sp_done", int'(done), 0);
        chk("sp_fail", int'(fail), 0);
        tick();
        chk("sp_done_after", int'(done), 0);

        // Invalid shape fails immediately.
        spawn(3'd7);
        do_rot(1'b0);
        chk("inv_fail", int'(fail), 1);
        chk("inv_q_valid", int'(q_valid), 0);
        tick();

        // O piece: four rotations, no queries, offsets never move.
        spawn(3'd0);
        for (int i = 0; i < 4; i++) begin
            do_rot(1'b0);
            chk("o_done", int'(done), 1);
            chk("o_q_valid", int'(q_valid), 0);
            chk("o_cur_rot", int'(cur_rot), (i + 1) % 4);
            chk_cells("o_cur", 1'b0, 1, 0, 2, 0, 1, 1, 2, 1);
        end
        tick();

        // Reset in the middle of a query.
        spawn(3'd6);
        do_rot(1'b0);
        chk("rq_q_valid_pre", int'(q_valid), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rq_q_valid", int'(q_valid), 0);
        chk("rq_busy", int'(busy), 0);
        chk("rq_cur_shape", int'(cur_shape), 0);
        chk("rq_cur_rot", int'(cur_rot), 0);
        chk("rq_cur_kick", int'($signed(cur_kick)), 0);
        chk("rq_done", int'(done), 0);
        chk("rq_fail", int'(fail), 0);
        tick();
        resetn = 1'b1;
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        chk("rq_discarded", int'(done), 0);
        chk("rq_idle", int'(busy), 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tetris_rotate_ctrl.md
TETRIS_ROTATE_CTRL -- requirements
Module: tetris_rotate_ctrl

Interface
REQ-001 SHALL have parameter NUM_KICKS, default 3, number of kick positions tried per rotation (1..4).
REQ-002 SHALL have parameter OFS_W, default 2, width of each cell offset output (>=2, zero-extended).
REQ-003 SHALL have parameter KICK_W, default 3, width of the signed kick value (two's complement).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port spawn_valid  in  1  load a new piece.
REQ-007 SHALL have port spawn_shape  in  3  shape id: O=0, I=1, T=2, S=3, Z=4, J=5, L=6, 7=invalid.
REQ-008 SHALL have port rot_req  in  1  single-cycle rotate request.
REQ-009 SHALL have port rot_dir  in  1  0=clockwise, 1=counter-clockwise; sampled with rot_req.
REQ-010 SHALL have port q_valid  out  1  collision query pending.
REQ-011 SHALL have port q_rot  out  2  candidate rotation.
REQ-012 SHALL have port q_kick  out  KICK_W  candidate x kick.
REQ-013 SHALL have port q_dx0..q_dx3, q_dy0..q_dy3  out  OFS_W each  candidate cell offsets.
REQ-014 SHALL have port q_ready  in  1  checker accepts query; q_hit valid this cycle.
REQ-015 SHALL have port q_hit  in  1  1=candidate collides.
REQ-016 SHALL have port cur_shape  out  3, cur_rot  out  2, cur_kick  out  KICK_W  committed piece state.
REQ-017 SHALL have port cur_dx0..cur_dx3, cur_dy0..cur_dy3  out  OFS_W each  committed cell offsets.
REQ-018 SHALL have ports busy, done, fail  out  1 each  status; done/fail are one-cycle pulses.

Function
REQ-019 SHALL define rot-0 cells (x,y) in a 4x4 box: O (1,0)(2,0)(1,1)(2,1); I (0,1)(1,1)(2,1)(3,1); T (1,0)(0,1)(1,1)(2,1); S (1,0)(2,0)(0,1)(1,1); Z (0,0)(1,0)(1,1)(2,1); J (0,0)(0,1)(1,1)(2,1); L (2,0)(0,1)(1,1)(2,1).
REQ-020 SHALL derive each clockwise step as (x,y)->(N-1-y, x), N=4 for I, N=3 for T/S/Z/J/L; O offsets SHALL be rotation-invariant.
REQ-021 SHALL emit cells 0..3 sorted row-major (ascending y, then ascending x); shape 7 SHALL give all offsets 0.
REQ-022 SHALL drive cur_* and q_* offsets combinationally from the registered shape/rotation (no added latency).
REQ-023 SHALL implement FSM states IDLE and QUERY; busy=1 exactly in QUERY.
REQ-024 SHALL, in IDLE on rot_req with cur_shape in 1..6, latch target=(cur_rot+1) mod 4 (cw) or (cur_rot-1) mod 4 (ccw), kick index k=0, and enter QUERY next cycle.
REQ-025 SHALL, on rot_req in IDLE with O, commit target rotation and pulse done next cycle without querying; shape 7 SHALL pulse fail instead.
REQ-026 SHALL use kick sequence k=0,1,2,3 -> 0,-1,+1,-2 (truncated to NUM_KICKS); q_kick = kick[k].
REQ-027 SHALL hold q_valid=1 and q_* stable in QUERY until q_ready=1.
REQ-028 SHALL, on q_ready & !q_hit, commit cur_rot=target, cur_kick=q_kick, pulse done next cycle, return IDLE.
REQ-029 SHALL, on q_ready & q_hit with k<NUM_KICKS-1, increment k and remain in QUERY; q_valid stays 1.
REQ-030 SHALL, on q_ready & q_hit with k=NUM_KICKS-1, leave cur_* unchanged, pulse fail next cycle, return IDLE.
REQ-031 SHALL ignore rot_req while busy (no queueing).
REQ-032 SHALL, on spawn_valid in any state, set cur_shape=spawn_shape, cur_rot=0, cur_kick=0, abort any query (q_valid=0 next cycle), return IDLE, no done/fail; spawn_valid SHALL win over simultaneous rot_req and q_ready.
REQ-033 SHALL treat cur_kick as the kick of the last committed rotation, not accumulated.

Reset
REQ-034 SHALL, while resetn=0, asynchronously force IDLE, cur_shape=0, cur_rot=0, cur_kick=0, q_valid=0, busy=0, done=0, fail=0, k=0.
REQ-035 SHALL, on reset mid-QUERY, drop q_valid immediately and discard the pending result.

Verification
REQ-036 SHALL check: spawn T, rot_req cw, q_ready=1 q_hit=0 first cycle -> q_rot=1, q cells (1,0)(1,1)(2,1)(1,2), done 1 cycle later, cur_rot=1, cur_kick=0.
REQ-037 SHALL check: spawn I, rot_req ccw, hits on kicks 0 and -1, clear on +1 -> q_kick 0,-1,+1 in order, cur_rot=3, cur_kick=+1, done pulse.
REQ-038 SHALL check: spawn J, cw rotate, q_hit=1 on all 3 kicks -> fail pulse, cur_rot=0, cur_kick=0, cur cells (0,0)(0,1)(1,1)(2,1).
REQ-039 SHALL check: q_ready held 0 for 5 cycles -> q_valid and q_* stable; second rot_req ignored.
REQ-040 SHALL check: spawn_valid (S) during QUERY with q_ready=1 -> no done/fail, cur_shape=3, cur_rot=0, q_valid=0 next cycle.
REQ-041 SHALL check: spawn O, 4 cw rotates -> 4 done pulses, no q_valid, offsets unchanged; resetn low mid-query -> all outputs at REQ-034 values.
